// File: rtl/btn_pkg.sv
// btn_pkg: shared per-button debounce FSM state type and button index constants
package btn_pkg;
    typedef enum logic [1:0] {RELEASED, ARMING, HELD, DISARMING} btn_state_t;
    localparam int BTN_JUMP = 2;
    localparam int BTN_RUN  = 1;
    localparam int BTN_DOWN = 0;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: single-button synchronizer + debounce FSM with press pulse (optional auto-repeat via BTN_AUTOREPEAT_EN)
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic button,
    output logic pressed
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("btn_debounce: parameter out of range");
    end
    logic [1:0] sync_q;
    logic s;
    btn_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic was;
    assign s = sync_q[1];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
            state  <= RELEASED;
            cnt    <= '0;
            was    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            state  <= state_d;
            cnt    <= cnt_d;
            was    <= button;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d   = '0;
        case (state)
            RELEASED:  if (s) begin
                           state_d = DIRECT ? HELD : ARMING;
                           cnt_d   = DIRECT ? '0 : ONE;
                       end
            ARMING:    if (!s)              state_d = RELEASED;
                       else if (cnt == LAST) state_d = HELD;
                       else                  cnt_d   = cnt + ONE;
            HELD:      if (!s) begin
                           state_d = DIRECT ? RELEASED : DISARMING;
                           cnt_d   = DIRECT ? '0 : ONE;
                       end
            DISARMING: if (s)               state_d = HELD;
                       else if (cnt == LAST) state_d = RELEASED;
                       else                  cnt_d   = cnt + ONE;
        endcase
    end
    assign button = (state == HELD) || (state == DISARMING);
`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rpt;
    logic rep;
    // timer restarts at 0 on every HELD entry, so a repeat lands REPEAT_CYCLES after the entry cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt <= '0;
            rep <= 1'b0;
        end else begin
            rpt <= (state != HELD || rpt == RLAST) ? '0 : rpt + RW'(1);
            rep <= (state == HELD) && (state_d == HELD) && (rpt == RLAST);
        end
    end
    assign pressed = (button & ~was) | rep;
`else
    assign pressed = button & ~was;
`endif
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: three independent debounced buttons (bit2 jump, bit1 run, bit0 down) with press pulses
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] raw_buttons,
    output logic [2:0] buttons,
    output logic [2:0] pressed
);
    for (genvar i = 0; i < 3; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_btn (
            .clk    (clk),
            .reset  (reset),
            .raw    (raw_buttons[i]),
            .button (buttons[i]),
            .pressed(pressed[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] raw = 3'b000;
    logic [2:0] raw1 = 3'b000;
    logic [2:0] buttons, pressed, b1, p1;
    int errors = 0;
    int checks = 0;
    int pc[3];
    logic [2:0] seen_b, seen_p;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .raw_buttons(raw), .buttons(buttons), .pressed(pressed)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(1), .REPEAT_CYCLES(16)) dut1 (
        .clk(clk), .reset(reset), .raw_buttons(raw1), .buttons(b1), .pressed(p1)
    );

    task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++) pc[k] = 0;
        seen_b = 3'b000;
        seen_p = 3'b000;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) pc[k] += int'(pressed[k]);
            seen_b |= buttons;
            seen_p |= pressed;
        end
    endtask

    initial begin
        clr();
        #2;
        chk("reset_buttons", buttons, 3'b000);
        chk("reset_pressed", pressed, 3'b000);
        tick(2);
        reset = 1'b1;
        tick(2);
        // clean press on jump
        raw = 3'b100;
        tick(5);
        chk("clean_before", buttons, 3'b000);
        tick();
        chk("clean_rise", buttons, 3'b100);
        chk("clean_pulse", pressed, 3'b100);
        tick();
        chk("clean_pulse_end", pressed, 3'b000);
        chk("clean_hold", buttons, 3'b100);
        clr();
        raw = 3'b000;
        tick(5);
        chk("release_before", buttons, 3'b100);
        tick();
        chk("release_fall", buttons, 3'b000);
        chk("release_no_pulse", seen_p, 3'b000);
        // bounce on run
        clr();
        raw = 3'b010; tick();
        raw = 3'b000; tick();
        raw = 3'b010; tick();
        raw = 3'b000; tick();
        raw = 3'b010;
        tick(5);
        chk("bounce_no_output", seen_b, 3'b000);
        tick();
        chk("bounce_rise", buttons, 3'b010);
        tick(2);
        chk("bounce_one_pulse", 3'(pc[1]), 3'd1);
        raw = 3'b000;
        tick(8);
        chk("bounce_released", buttons, 3'b000);
        // two-cycle glitch on down
        clr();
        raw = 3'b001;
        tick(2);
        raw = 3'b000;
        tick(8);
        chk("glitch_buttons", seen_b, 3'b000);
        chk("glitch_pressed", seen_p, 3'b000);
        // simultaneous press and partial release
        raw = 3'b101;
        tick(5);
        chk("simul_before", buttons, 3'b000);
        tick();
        chk("simul_rise", buttons, 3'b101);
        chk("simul_pulse", pressed, 3'b101);
        tick();
        chk("simul_pulse_end", pressed, 3'b000);
        clr();
        raw = 3'b001;
        tick(5);
        chk("partial_before", buttons, 3'b101);
        tick();
        chk("partial_fall", buttons, 3'b001);
        chk("partial_no_pulse", seen_p, 3'b000);
        raw = 3'b000;
        tick(8);
        chk("simul_released", buttons, 3'b000);
        // single-cycle debounce bypasses ARMING/DISARMING
        raw1 = 3'b001;
        tick(2);
        chk("d1_before", b1, 3'b000);
        tick();
        chk("d1_rise", b1, 3'b001);
        chk("d1_pulse", p1, 3'b001);
        tick();
        chk("d1_pulse_end", p1, 3'b000);
        raw1 = 3'b000;
        tick(2);
        chk("d1_hold", b1, 3'b001);
        tick();
        chk("d1_fall", b1, 3'b000);
        // reset in the middle of a hold
        raw = 3'b100;
        tick(6);
        chk("prereset_hold", buttons, 3'b100);
        reset = 1'b0;
        #1;
        chk("async_reset_buttons", buttons, 3'b000);
        chk("async_reset_pressed", pressed, 3'b000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clr();
        tick(5);
        chk("postreset_before", buttons, 3'b000);
        tick();
        chk("postreset_rise", buttons, 3'b100);
        chk("postreset_pulse", pressed, 3'b100);
        clr();
        tick(40);
`ifdef BTN_AUTOREPEAT_EN
        chk("repeat_pulses", 3'(pc[2]), 3'd2);
`else
        chk("repeat_pulses", 3'(pc[2]), 3'd0);
`endif
        clr();
        raw = 3'b000;
        tick(10);
        chk("after_release_pulses", seen_p, 3'b000);
        chk("final_buttons", buttons, 3'b000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
